// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous RAM between the video fetch
// engine and the CPU. Video always wins the slot and sees a fixed one-cycle read
// latency. CPU writes are posted into a small FIFO and drained in idle slots.
// CPU reads either hit the FIFO (forwarded from the youngest matching entry) or
// wait for a free slot and read the RAM.
//
// CPU handshake: cpu_req is raised with cpu_we/cpu_addr/cpu_wdata stable and is
// held until cpu_ack. cpu_ack is a one-cycle registered pulse that completes
// exactly one transaction. On reads, cpu_rdata is valid in the same cycle as
// cpu_ack. During the ack cycle cpu_req is ignored, so the requester may change
// its request (or present a new one) from the next cycle on.
module vram_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          vid_req,
    input  logic [AW-1:0]                 vid_addr,
    output logic [DW-1:0]                 vid_data,
    output logic                          vid_valid,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [AW-1:0]                 cpu_addr,
    input  logic [DW-1:0]                 cpu_wdata,
    output logic                          cpu_ack,
    output logic [DW-1:0]                 cpu_rdata,
    output logic [AW-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    output logic                          mem_we,
    input  logic [DW-1:0]                 mem_rdata,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
    output logic [1:0]                    dbg_cpu_state
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_RDATA = 2'd1,
        C_ACK   = 2'd2
    } cpu_state_t;

    cpu_state_t        state, state_nxt;

    // Posted-write FIFO storage and bookkeeping
    logic [AW-1:0]     buf_addr [WBUF_DEPTH];
    logic [DW-1:0]     buf_data [WBUF_DEPTH];
    logic [PW-1:0]     head, tail;
    logic [LW-1:0]     level;

    logic              wb_full, wb_empty;
    logic              hit;
    logic [DW-1:0]     fwd_data;
    logic              push, pop, rd_issue, fwd_take;

    // full/empty reflect the FIFO as it stands at the start of the cycle
    assign wb_full  = (level == LW'(WBUF_DEPTH));
    assign wb_empty = (level == '0);

    // Search the FIFO oldest-to-youngest so the youngest match wins; the head
    // entry counts even if it is being drained this very cycle.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if ((LW'(i) < level) && (buf_addr[head + PW'(i)] == cpu_addr)) begin
                hit      = 1'b1;
                fwd_data = buf_data[head + PW'(i)];
            end
        end
    end

    // CPU FSM next state and the per-cycle CPU actions
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        rd_issue  = 1'b0;
        fwd_take  = 1'b0;
        case (state)
            C_IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        if (!wb_full) begin
                            push      = 1'b1;
                            state_nxt = C_ACK;
                        end
                    end else if (hit) begin
                        fwd_take  = 1'b1;
                        state_nxt = C_ACK;
                    end else if (!vid_req) begin
                        rd_issue  = 1'b1;
                        state_nxt = C_RDATA;
                    end
                end
            end
            C_RDATA: state_nxt = C_ACK;
            C_ACK:   state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
    end

    // Slot owner: video, then CPU read issue, then FIFO drain
    always_comb begin
        pop       = !vid_req && !rd_issue && !wb_empty;
        mem_we    = pop;
        mem_wdata = buf_data[head];
        if (vid_req) begin
            mem_addr = vid_addr;
        end else if (rd_issue) begin
            mem_addr = cpu_addr;
        end else begin
            mem_addr = buf_addr[head];
        end
    end

    // FIFO payload; reset only clears the pointers, the stale payload is never read
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= cpu_addr;
            buf_data[tail] <= cpu_wdata;
        end
    end

    // State register, FIFO pointers and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= C_IDLE;
            head      <= '0;
            tail      <= '0;
            level     <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            vid_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            vid_valid <= vid_req;
            cpu_ack   <= (state_nxt == C_ACK);
            if (fwd_take) begin
                cpu_rdata <= fwd_data;
            end else if (state == C_RDATA) begin
                cpu_rdata <= mem_rdata;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign vid_data      = mem_rdata;
    assign wbuf_level    = level;
    assign dbg_cpu_state = state;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: self-checking bench for vram_arbiter. A RAM model sits on the
// memory port; a program-order memory model (posted writes held in exp_q, RAM
// behind them) predicts every CPU read, the drain order and the buffer level.
module tb_vram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    wbuf_level;
    logic [1:0]    dbg_cpu_state;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]    ram [0:65535];
    logic [AW+DW-1:0] exp_q[$];
    int               vid_mode = 0;
    logic             vid_pend = 1'b0;
    logic [DW-1:0]    vid_exp  = '0;

    vram_arbiter #(.AW(AW), .DW(DW), .WBUF_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .wbuf_level(wbuf_level), .dbg_cpu_state(dbg_cpu_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Program-order view: youngest posted write to the address, else the RAM
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i][AW+DW-1:DW] == a) return exp_q[i][DW-1:0];
        end
        return ram[a];
    endfunction

    // Synchronous single-port RAM: write and registered read on posedge
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Video requester: 0 = idle, 1 = continuous, 2 = random
    initial begin
        vid_req  = 1'b0;
        vid_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            vid_addr = 16'($urandom);
            case (vid_mode)
                1:       vid_req = 1'b1;
                2:       vid_req = ($urandom_range(0, 9) < 4);
                default: vid_req = 1'b0;
            endcase
        end
    end

    // Scoreboard: video data, CPU read data, buffer level and drain order
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (!resetn) begin
            exp_q.delete();
            vid_pend = 1'b0;
        end else begin
            check_eq("vid_valid", vid_valid, vid_pend);
            if (vid_pend) check_eq("vid_data", vid_data, vid_exp);
            vid_pend = vid_req;
            vid_exp  = ram[vid_addr];
            if (cpu_ack && cpu_we) exp_q.push_back({cpu_addr, cpu_wdata});
            if (cpu_ack && !cpu_we) check_eq("rd_data", cpu_rdata, model_read(cpu_addr));
            check_eq("level", wbuf_level, exp_q.size());
            if (vid_req) check_eq("we_under_vid", mem_we, 1'b0);
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check_eq("drain_unexpected", mem_we, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("drain_addr", mem_addr, e[AW+DW-1:DW]);
                    check_eq("drain_data", mem_wdata, e[DW-1:0]);
                end
            end
        end
    end

    // Driver tasks; all are entered and left just after a posedge
    task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic wait_ack(input int max, input logic chk_issue, output int lat);
        lat = 0;
        for (int n = 1; n <= max; n++) begin
            @(negedge clk);
            if (n == 1 && chk_issue) begin
                check_eq("issue_addr", mem_addr, cpu_addr);
                check_eq("issue_we", mem_we, 1'b0);
            end
            if (cpu_ack) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) check_eq("ack_timeout", cpu_ack, 1'b1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic do_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int exp_lat, input logic chk_issue);
        int lat;
        cpu_start(we, a, d);
        wait_ack(200, chk_issue, lat);
        if (exp_lat > 0) check_eq("latency", lat, exp_lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty();
        int ok;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (wbuf_level == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) check_eq("drain_timeout", wbuf_level, 0);
        @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
        ram[16'h2000] = 8'h3C;
        ram[16'h2004] = 8'h77;
        resetn    = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ack", cpu_ack, 1'b0);
        check_eq("rst_rdata", cpu_rdata, 8'h00);
        check_eq("rst_level", wbuf_level, 3'd0);
        check_eq("rst_vid_valid", vid_valid, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);

        // Buffer fills under continuous video; fifth write stalls until drain
        vid_mode = 1;
        idle(1);
        for (int i = 0; i < 4; i++) do_op(1'b1, 16'h1000 + 16'(i), 8'hA0 + 8'(i), 2, 1'b0);
        cpu_start(1'b1, 16'h1004, 8'hA4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("t2_stall_ack", cpu_ack, 1'b0);
            check_eq("t2_full_level", wbuf_level, 3'd4);
        end
        @(posedge clk);
        #1;
        vid_mode = 0;
        do_op(1'b1, 16'h1004, 8'hA4, 0, 1'b0);
        wait_empty();

        // Forwarding from the youngest buffered write
        vid_mode = 1;
        idle(1);
        do_op(1'b1, 16'h1000, 8'hAA, 2, 1'b0);
        do_op(1'b1, 16'h1000, 8'h55, 2, 1'b0);
        do_op(1'b0, 16'h1000, 8'h00, 2, 1'b0);
        check_eq("t3_fwd_data", cpu_rdata, 8'h55);
        vid_mode = 0;
        wait_empty();

        // Plain RAM read: issue at T, ack and data at T+2
        do_op(1'b0, 16'h2000, 8'h00, 3, 1'b1);
        check_eq("t4_rdata", cpu_rdata, 8'h3C);

        // Video holds the slot for six cycles while a read waits
        vid_mode = 1;
        cpu_start(1'b0, 16'h2004, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("t5_stall_ack", cpu_ack, 1'b0);
        end
        @(posedge clk);
        #1;
        vid_mode = 0;
        begin
            int lat;
            wait_ack(20, 1'b1, lat);
            check_eq("t5_latency", lat, 3);
        end
        check_eq("t5_rdata", cpu_rdata, 8'h77);

        // Reset with three posted writes and video running: writes are discarded
        vid_mode = 1;
        idle(1);
        for (int i = 0; i < 3; i++) do_op(1'b1, 16'h4000 + 16'(i), 8'hE0 + 8'(i), 2, 1'b0);
        resetn   = 1'b0;
        vid_mode = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t6_rst_ack", cpu_ack, 1'b0);
            check_eq("t6_rst_vid_valid", vid_valid, 1'b0);
            check_eq("t6_rst_level", wbuf_level, 3'd0);
            check_eq("t6_rst_we", mem_we, 1'b0);
            check_eq("t6_rst_rdata", cpu_rdata, 8'h00);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t6_post_we", mem_we, 1'b0);
            check_eq("t6_post_level", wbuf_level, 3'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 16'h4000 + 16'(i), 8'h00, 3, 1'b1);
            check_eq("t6_ram_kept", cpu_rdata, pat(16'h4000 + 16'(i)));
        end

        // Randomized mix of reads and writes over a small address window
        vid_mode = 2;
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(0, 1)), 16'h3000 + 16'($urandom_range(0, 5)),
                  8'($urandom), 0, 1'b0);
            idle($urandom_range(0, 2));
        end
        vid_mode = 0;
        wait_empty();
        for (int i = 0; i < 6; i++) do_op(1'b0, 16'h3000 + 16'(i), 8'h00, 3, 1'b0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
